// File: rtl/ysyx_lsu_resp.sv
// LSU responder: takes one EXU load/store request, runs a single-beat AXI4-Lite
// style read or write, and returns extended load data or store completion as a pulse.
module ysyx_lsu_resp #(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exu_avalid,
    input  logic             exu_ren,
    input  logic             exu_wen,
    input  logic [BIT_W-1:0] exu_addr,
    input  logic [BIT_W-1:0] exu_wdata,
    input  logic [2:0]       exu_funct3,
    output logic [BIT_W-1:0] lsu_rdata_o,
    output logic             lsu_rvalid_o,
    output logic             lsu_wready_o,
    output logic             lsu_err_o,
    output logic [BIT_W-1:0] bus_araddr,
    output logic             bus_arvalid,
    input  logic             bus_arready,
    input  logic [BIT_W-1:0] bus_rdata,
    input  logic [1:0]       bus_rresp,
    input  logic             bus_rvalid,
    output logic             bus_rready,
    output logic [BIT_W-1:0] bus_awaddr,
    output logic             bus_awvalid,
    input  logic             bus_awready,
    output logic [BIT_W-1:0] bus_wdata,
    output logic [3:0]       bus_wstrb,
    output logic             bus_wvalid,
    input  logic             bus_wready,
    input  logic [1:0]       bus_bresp,
    input  logic             bus_bvalid,
    output logic             bus_bready
);

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WREQ,
        WRESP,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [BIT_W-1:0] addr_q;
    logic [BIT_W-1:0] wdata_q;
    logic [BIT_W-1:0] rdata_q;
    logic [3:0]       wstrb_q;
    logic [2:0]       f3_q;
    logic             load_q;
    logic             err_q;
    logic             aw_done;
    logic             w_done;

    logic             req;
    logic             req_bad;
    logic [1:0]       req_off;
    logic [3:0]       req_strb;
    logic             aw_fire;
    logic             w_fire;
    logic [BIT_W-1:0] lane;
    logic [BIT_W-1:0] load_ext;

    // Request decode: alignment and funct3 legality, evaluated only in IDLE.
    always_comb begin
        req_off  = exu_addr[1:0];
        req      = exu_avalid & (exu_ren | exu_wen);
        req_bad  = exu_ren & exu_wen;
        req_strb = 4'b1111;
        case (exu_funct3)
            3'b000, 3'b100: req_strb = 4'b0001 << req_off;
            3'b001, 3'b101: begin
                req_strb = 4'b0011 << req_off;
                if (req_off[0]) req_bad = 1'b1;
            end
            3'b010: begin
                req_strb = 4'b1111;
                if (req_off != 2'b00) req_bad = 1'b1;
            end
            default: req_bad = 1'b1;
        endcase
    end

    // Load lane select and extension use the latched request, not live EXU inputs.
    always_comb begin
        lane = bus_rdata >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{(BIT_W-8){lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{(BIT_W-16){lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {{(BIT_W-8){1'b0}}, lane[7:0]};
            3'b101:  load_ext = {{(BIT_W-16){1'b0}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    assign aw_fire = bus_awvalid & bus_awready;
    assign w_fire  = bus_wvalid & bus_wready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (req_bad)      state_nxt = DONE;
                    else if (exu_ren) state_nxt = RADDR;
                    else              state_nxt = WREQ;
                end
            end
            RADDR: if (bus_arready) state_nxt = RDATA;
            RDATA: if (bus_rvalid)  state_nxt = DONE;
            WREQ: begin
                if ((aw_done | aw_fire) & (w_done | w_fire)) state_nxt = WRESP;
            end
            WRESP: if (bus_bvalid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wstrb_q <= '0;
            f3_q    <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= exu_addr;
                        wdata_q <= exu_wdata << {req_off, 3'b000};
                        wstrb_q <= req_strb;
                        f3_q    <= exu_funct3;
                        load_q  <= exu_ren;
                        err_q   <= req_bad;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                RDATA: begin
                    if (bus_rvalid) begin
                        rdata_q <= load_ext;
                        err_q   <= (bus_rresp != 2'b00);
                    end
                end
                WREQ: begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                end
                WRESP: begin
                    if (bus_bvalid) err_q <= (bus_bresp != 2'b00);
                end
                default: ;
            endcase
        end
    end

    // AW and W valids drop independently once their own handshake has happened.
    always_comb begin
        lsu_rdata_o  = rdata_q;
        lsu_rvalid_o = 1'b0;
        lsu_wready_o = 1'b0;
        lsu_err_o    = 1'b0;
        bus_araddr   = {addr_q[BIT_W-1:2], 2'b00};
        bus_awaddr   = {addr_q[BIT_W-1:2], 2'b00};
        bus_wdata    = wdata_q;
        bus_wstrb    = wstrb_q;
        bus_arvalid  = 1'b0;
        bus_rready   = 1'b0;
        bus_awvalid  = 1'b0;
        bus_wvalid   = 1'b0;
        bus_bready   = 1'b0;
        case (state)
            RADDR: bus_arvalid = 1'b1;
            RDATA: bus_rready  = 1'b1;
            WREQ: begin
                bus_awvalid = ~aw_done;
                bus_wvalid  = ~w_done;
            end
            WRESP: bus_bready = 1'b1;
            DONE: begin
                lsu_rvalid_o = load_q;
                lsu_wready_o = ~load_q;
                lsu_err_o    = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ysyx_lsu_resp.md
Name: ysyx_lsu_resp

Overview:
- LSU-side responder for the EXU load/store request handshake (avalid / rvalid / wready).
- Accepts one request at a time from EXU and aligns store data into byte lanes with strobes.
- Runs an AXI4-Lite-style single-beat read or write on the memory bus.
- Returns sign/zero-extended load data, or store completion, to EXU as a one-cycle pulse.

Parameters:
- BIT_W, 32: data/address width; only 32 is supported.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low (low = reset)
- exu_avalid  input  1  EXU request valid; held high until rvalid or wready is returned
- exu_ren  input  1  load request
- exu_wen  input  1  store request
- exu_addr  input  BIT_W  byte address
- exu_wdata  input  BIT_W  store data, right-aligned
- exu_funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- lsu_rdata_o  output  BIT_W  extended load data, valid with lsu_rvalid_o
- lsu_rvalid_o  output  1  load-done pulse
- lsu_wready_o  output  1  store-done pulse
- lsu_err_o  output  1  fault flag, valid with either done pulse
- bus_araddr  output  BIT_W  read address
- bus_arvalid  output  1  read address valid
- bus_arready  input  1  read address ready
- bus_rdata  input  BIT_W  read data
- bus_rresp  input  2  read response
- bus_rvalid  input  1  read data valid
- bus_rready  output  1  read data ready
- bus_awaddr  output  BIT_W  write address
- bus_awvalid  output  1  write address valid
- bus_awready  input  1  write address ready
- bus_wdata  output  BIT_W  write data
- bus_wstrb  output  4  write byte strobes
- bus_wvalid  output  1  write data valid
- bus_wready  input  1  write data ready
- bus_bresp  input  2  write response
- bus_bvalid  input  1  write response valid
- bus_bready  output  1  write response ready

Behaviour:
- Reset state: FSM IDLE; every output 0, including lsu_rdata_o and all bus valid/ready signals.
- Reset mid-transaction abandons the access. No done pulse follows reset release.
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- IDLE, request capture: when exu_avalid & (exu_ren ^ exu_wen), latch addr, wdata, funct3 and direction.
  - Load goes to RADDR.
  - Store goes to WREQ.
- IDLE, error cases (go straight to DONE with err=1, no bus access):
  - exu_ren & exu_wen both set.
  - Misaligned access: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Unsupported funct3.
- RADDR: bus_arvalid=1, araddr = {addr[31:2],2'b00}. On arready, go to RDATA.
- RDATA: bus_rready=1. On rvalid:
  - Shift rdata right by 8×addr[1:0].
  - Sign/zero-extend per funct3.
  - Latch into lsu_rdata_o; err = (rresp≠0); go to DONE.
- WREQ: bus_awvalid and bus_wvalid both raised.
  - Each drops independently after its own ready; AW and W may complete in either order or the same cycle.
  - When both have completed, go to WRESP.
  - wdata = exu_wdata << 8×addr[1:0].
  - wstrb: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
- WRESP: bus_bready=1. On bvalid, err = (bresp≠0); go to DONE.
- DONE (exactly 1 cycle), then return to IDLE:
  - Load: lsu_rvalid_o=1.
  - Store: lsu_wready_o=1.
  - Error with neither ren nor wen valid: use the ren pulse if exu_ren, else the wready pulse.
- No re-accept: requests are never sampled in DONE, because EXU still holds exu_avalid during the pulse cycle. A new request is accepted from IDLE the cycle after DONE at the earliest.
- lsu_rdata_o holds its value until the next load completes.
- Minimum latency, zero-wait bus:
  - Load: accept cycle, +1 RADDR, +1 RDATA, then pulse → pulse 3 cycles after acceptance.
  - Store: pulse 3 cycles after acceptance.
- Bus valids are held until their ready arrives, with address and data stable, regardless of exu_avalid.

Test Plan:
- LB, addr 0x80000003, bus_rdata 0x80FF1234, zero-wait → lsu_rdata_o=0xFFFFFF80, rvalid pulse 3 cycles after accept, err=0.
- LHU, addr 0x80000002, rdata 0xBEEF0000, arready delayed 4 cycles → araddr held at 0x80000000 throughout; lsu_rdata_o=0x0000BEEF.
- SB, addr 0x10000001, wdata 0x000000AA:
  - With awready 2 cycles before wready → wdata=0x0000AA00, wstrb=0010, single wready pulse after bvalid.
  - Repeat with wready before awready → same result.
- SW, addr 0x10000002 → no bus activity, wready pulse with err=1 one cycle after accept; LW with rresp=2'b10 → rvalid pulse with err=1.
- Back-to-back SW then LW with exu_avalid held through the pulse → exactly two bus transactions and two pulses, no duplicate accept.
- rst low during RDATA → all outputs 0 asynchronously; after release, no stray pulse, and next request completes normally.
